// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: one nibble per clock through a 4-bit ripple-carry core, carry kept in a flop.
// Latency: result and done appear NIBBLES+1 cycles after start; start is ignored while busy (no queueing).

module rca_fa4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c3   = c[3];
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   sum_sh_q, sum_sh_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;

  logic [3:0]     s4;
  logic           c4;
  logic           c3_unused;
  logic [3:0]     sum_sh_unused;

  rca_fa4bit u_rca (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (s4),
    .c3   (c3_unused),
    .cout (c4)
  );

  // The lowest nibble of the sum shifter falls off each shift and is never read.
  assign sum_sh_unused = sum_sh_q[3:0];

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d  = c4;
        a_sh_d   = {4'b0000, a_sh_q[W-1:4]};
        b_sh_d   = {4'b0000, b_sh_q[W-1:4]};
        sum_sh_d = {s4, sum_sh_q[W-1:4]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {s4, sum_sh_q[W-1:4]};
          cout_d  = c4;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vector table, multi-cycle corner sequences, random ops vs an arithmetic model.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Present operands with start high for exactly one edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called just after the accepting edge; ends in the done cycle.
  task automatic wait_result(input string name, input logic [W-1:0] es, input logic ec);
    for (int i = 0; i < N; i++) begin
      check({name, " busy"}, 32'(busy), 32'd1);
      check({name, " done-early"}, 32'(done), 32'd0);
      check({name, " sum-held"}, 32'(sum), 32'(prev_sum));
      check({name, " cout-held"}, 32'(cout), 32'(prev_cout));
      step();
    end
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " busy-off"}, 32'(busy), 32'd0);
    check({name, " sum"}, 32'(sum), 32'(es));
    check({name, " cout"}, 32'(cout), 32'(ec));
    prev_sum = es;
    prev_cout = ec;
  endtask

  task automatic check_idle(input string name);
    check({name, " idle-done"}, 32'(done), 32'd0);
    check({name, " idle-busy"}, 32'(busy), 32'd0);
    check({name, " idle-sum"}, 32'(sum), 32'(prev_sum));
  endtask

  initial begin
    vec_t vecs[7];
    logic [W:0] r;
    int done_cnt;
    int done_at;

    vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, s: 16'h5555, co: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, co: 1'b1};
    vecs[2] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, s: 16'h0000, co: 1'b1};
    vecs[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, s: 16'h0000, co: 1'b0};
    vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, co: 1'b1};
    vecs[5] = '{a: 16'h0F0F, b: 16'hF0F0, cin: 1'b1, s: 16'h0000, co: 1'b1};
    vecs[6] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0};

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0;
    start = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'h0);
    check("reset cout", 32'(cout), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    check("post-reset busy", 32'(busy), 32'd0);
    prev_sum = '0;
    prev_cout = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co);
      step();
      check_idle($sformatf("vec%0d", i));
    end

    // start during RUN is ignored.
    start_op(16'h0001, 16'h0001, 1'b0);
    done_cnt = 0;
    done_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (i < 3) begin
        a = 16'hFFFF;
        b = 16'hFFFF;
        cin = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check("busy-start done count", 32'(done_cnt), 32'd1);
    check("busy-start done cycle", 32'(done_at), 32'd4);
    check("busy-start sum", 32'(sum), 32'h0002);
    check("busy-start cout", 32'(cout), 32'd0);
    prev_sum = 16'h0002;
    prev_cout = 1'b0;

    // Back-to-back: start held in the DONE cycle.
    start_op(16'h1111, 16'h2222, 1'b0);
    wait_result("b2b first", 16'h3333, 1'b0);
    start_op(16'h00F0, 16'h0010, 1'b0);
    wait_result("b2b second", 16'h0100, 1'b0);
    step();
    check_idle("b2b");

    // Reset at the second RUN edge aborts the operation.
    start_op(16'h1234, 16'h1111, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum", 32'(sum), 32'h0);
    check("abort cout", 32'(cout), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      step();
    end
    check("abort no done", 32'(done_cnt), 32'd0);
    prev_sum = '0;
    prev_cout = 1'b0;
    start_op(16'h0F0F, 16'h00F1, 1'b0);
    wait_result("after abort", 16'h1000, 1'b0);
    step();

    // Random operations, randomly back-to-back or separated by idle.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = '1;
      r = ref_add(ra, rb, rc);
      start_op(ra, rb, rc);
      wait_result($sformatf("rand%0d", i), r[W-1:0], r[W]);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check_idle($sformatf("rand%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
